// File: rtl/tube_scan_ctrl.sv
// rtl/tube_scan_ctrl.sv - scan scheduler for the three multiplexed 7-segment tubes
// DATA/CTRL/STATUS register port, frame-synchronous shadow, BLANK/SHOW digit scan.
module tube_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  function automatic logic [7:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 8'hC0;  4'h1: enc = 8'hF9;  4'h2: enc = 8'hA4;  4'h3: enc = 8'hB0;
      4'h4: enc = 8'h99;  4'h5: enc = 8'h92;  4'h6: enc = 8'h82;  4'h7: enc = 8'hF8;
      4'h8: enc = 8'h80;  4'h9: enc = 8'h90;  4'hA: enc = 8'h88;  4'hB: enc = 8'h83;
      4'hC: enc = 8'hC6;  4'hD: enc = 8'hA1;  4'hE: enc = 8'h86;  default: enc = 8'h8E;
    endcase
  endfunction

  logic [31:0]   r_data;
  logic [31:0]   r_shadow;
  logic [5:0]    r_ctrl;
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_sel;
  logic [7:0]    r_seg0;
  logic [7:0]    r_seg1;
  logic [7:0]    r_seg2;
  logic          r_sel2;

  logic [31:0]   w_data_nxt;
  logic [5:0]    w_ctrl_nxt;
  logic [31:0]   w_shadow_nxt;
  logic          w_run;
  logic [0:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic          w_show;
  logic          w_sel2_nxt;

  always_comb begin
    w_data_nxt = r_data;
    if (we && addr == 2'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) w_data_nxt[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    w_ctrl_nxt = r_ctrl;
    if (we && addr == 2'd1 && byte_en[0]) w_ctrl_nxt = wdata[5:0];
  end

  // Scanning only advances when enabled both before and after this edge, so an
  // enabling write leaves the counters at a frame start for one full cycle.
  assign w_run        = r_ctrl[5] & w_ctrl_nxt[5];
  assign w_shadow_nxt = (w_run && r_cnt == '0 && r_idx == 2'd0) ? r_data : r_shadow;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    if (!w_run) begin
      w_state_nxt = ST_BLANK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 2'd0;
    end else if (r_state == ST_BLANK) begin
      if (r_cnt == BLANK_LAST) w_state_nxt = ST_SHOW;
    end else if (r_cnt == SLOT_LAST) begin
      w_state_nxt = ST_BLANK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = r_idx + 2'd1;
    end
  end

  // Outputs are computed from next-state values so they move on the same edge as the FSM.
  assign w_show     = (w_state_nxt == ST_SHOW);
  assign w_sel2_nxt = w_ctrl_nxt[4] & w_ctrl_nxt[5];

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_data   <= 32'h0;
      r_shadow <= 32'h0;
      r_ctrl   <= 6'h20;
      r_state  <= ST_BLANK;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_sel    <= 4'h0;
      r_seg0   <= 8'hFF;
      r_seg1   <= 8'hFF;
      r_seg2   <= 8'hFF;
      r_sel2   <= 1'b0;
    end else begin
      r_data   <= w_data_nxt;
      r_shadow <= w_shadow_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_sel    <= w_show ? (4'b0001 << w_idx_nxt) : 4'h0;
      r_seg0   <= w_show ? enc(w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4]) : 8'hFF;
      r_seg1   <= w_show ? enc(w_shadow_nxt[{1'b1, w_idx_nxt, 2'b00} +: 4]) : 8'hFF;
      r_sel2   <= w_sel2_nxt;
      r_seg2   <= w_sel2_nxt ? enc(w_ctrl_nxt[3:0]) : 8'hFF;
    end
  end

  always_comb begin
    case (addr)
      2'd0:    rdata = r_data;
      2'd1:    rdata = {26'h0, r_ctrl};
      2'd2:    rdata = {29'h0, (r_state == ST_BLANK), r_idx};
      default: rdata = 32'h0;
    endcase
  end

  assign digital_tube0     = r_seg0;
  assign digital_tube1     = r_seg1;
  assign digital_tube2     = r_seg2;
  assign digital_tube_sel0 = r_sel;
  assign digital_tube_sel1 = r_sel;
  assign digital_tube_sel2 = r_sel2;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// tb/tb_tube_scan_ctrl.sv - self-checking bench for tube_scan_ctrl
// Register vector table, hand-written scan sequences, random traffic against a timeline model.
module tb_tube_scan_ctrl;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk_in = 1'b0;
  logic        sys_rstn;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  seg0, seg1, seg2;
  logic [3:0]  sel0, sel1;
  logic        sel2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] enc_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  tube_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .addr(addr), .we(we), .byte_en(byte_en),
    .wdata(wdata), .rdata(rdata),
    .digital_tube0(seg0), .digital_tube_sel0(sel0),
    .digital_tube1(seg1), .digital_tube_sel1(sel1),
    .digital_tube2(seg2), .digital_tube_sel2(sel2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  waddr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] m_data, m_shadow, d_old;
  logic [5:0]  m_ctrl;
  int          t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sys_rstn = 1'b0;
    we = 1'b0; addr = 2'd0; byte_en = 4'h0; wdata = 32'h0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    sys_rstn = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; we = 1'b1; byte_en = be; wdata = d;
    @(posedge clk_in);
    #1 we = 1'b0;
  endtask

  initial begin
    logic [7:0] f1_seg0 [4];
    logic [7:0] f1_seg1 [4];
    logic       en_old, show, e_sel2;
    logic [3:0] e_sel;
    logic [7:0] e_seg0, e_seg1, e_seg2;
    logic [31:0] e_rd;
    int off, slot;

    f1_seg0 = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    f1_seg1 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    vecs[0] = '{2'd0, 1'b0, 4'h0,    32'h0,        2'd0, 32'h0};
    vecs[1] = '{2'd0, 1'b0, 4'h0,    32'h0,        2'd1, 32'h20};
    vecs[2] = '{2'd0, 1'b1, 4'b0100, 32'h00EE0000, 2'd0, 32'h00EE0000};
    vecs[3] = '{2'd0, 1'b1, 4'b0001, 32'h12345678, 2'd0, 32'h00EE0078};
    vecs[4] = '{2'd0, 1'b1, 4'b1010, 32'hAABBCCDD, 2'd0, 32'hAAEECC78};
    vecs[5] = '{2'd1, 1'b1, 4'b1110, 32'hFFFFFFFF, 2'd1, 32'h20};
    vecs[6] = '{2'd1, 1'b1, 4'b0001, 32'hFFFFFFD5, 2'd1, 32'h15};
    vecs[7] = '{2'd2, 1'b1, 4'hF,    32'hFFFFFFFF, 2'd2, 32'h4};
    vecs[8] = '{2'd3, 1'b1, 4'hF,    32'h12345678, 2'd3, 32'h0};
    vecs[9] = '{2'd3, 1'b0, 4'h0,    32'h0,        2'd0, 32'hAAEECC78};

    // Register vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      addr = vecs[i].waddr; we = vecs[i].wr; byte_en = vecs[i].be; wdata = vecs[i].wd;
      @(posedge clk_in);
      #1 we = 1'b0; addr = vecs[i].raddr;
      #1 chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
      @(negedge clk_in);
    end

    // Boot scan, frame-start tear protection, mid-frame write
    do_reset();
    for (int k = 0; k < 95; k++) begin
      if (k > 0) @(negedge clk_in);
      we = 1'b0;
      if (k <= 10) begin
        chk("boot_sel0", {28'h0, sel0}, (k < 2) ? 32'h0 : (k < 8) ? 32'h1 : (k < 10) ? 32'h0 : 32'h2);
        chk("boot_sel1", {28'h0, sel1}, {28'h0, sel0});
      end
      if (k <= 7) chk("boot_seg0", {24'h0, seg0}, (k < 2) ? 32'hFF : 32'hC0);
      if (k >= 32 && k < 64 && (k % SD) == BC) begin
        chk("f1_sel0", {28'h0, sel0}, 32'h1 << ((k - 32) / SD));
        chk("f1_seg0", {24'h0, seg0}, {24'h0, f1_seg0[(k - 32) / SD]});
        chk("f1_seg1", {24'h0, seg1}, {24'h0, f1_seg1[(k - 32) / SD]});
      end
      if (k == 66 || k == 93) begin
        chk("f2_seg0", {24'h0, seg0}, 32'h8E);
        chk("f2_seg1", {24'h0, seg1}, 32'h8E);
        chk("f2_sel1", {28'h0, sel1}, (k == 66) ? 32'h1 : 32'h8);
      end
      if (k == 0 || k == 51) begin
        addr = 2'd0; we = 1'b1; byte_en = 4'hF;
        wdata = (k == 0) ? 32'h1234ABCD : 32'hFFFFFFFF;
      end
    end

    // Tube2 and scan disable
    @(negedge clk_in);
    wr(2'd1, 4'h1, 32'h37);
    @(negedge clk_in);
    chk("ctrl37_sel2", {31'h0, sel2}, 32'h1);
    chk("ctrl37_seg2", {24'h0, seg2}, 32'hF8);
    wr(2'd1, 4'h1, 32'h17);
    addr = 2'd2;
    @(negedge clk_in);
    chk("ctrl17_sel", {23'h0, sel2, sel1, sel0}, 32'h0);
    chk("ctrl17_seg", {8'h0, seg2, seg1, seg0}, 32'hFFFFFF);
    chk("ctrl17_status", rdata, 32'h4);

    // Re-enable, then asynchronous reset in the middle of digit 3
    wr(2'd1, 4'h1, 32'h20);
    @(negedge clk_in);
    repeat (26) @(negedge clk_in);
    chk("reen_sel0", {28'h0, sel0}, 32'h8);
    chk("reen_seg0", {24'h0, seg0}, 32'h8E);
    #2 sys_rstn = 1'b0;
    #1;
    chk("arst_sel", {23'h0, sel2, sel1, sel0}, 32'h0);
    chk("arst_seg", {8'h0, seg2, seg1, seg0}, 32'hFFFFFF);
    addr = 2'd0;
    #1 chk("arst_data", rdata, 32'h0);
    addr = 2'd1;
    #1 chk("arst_ctrl", rdata, 32'h20);

    // Random traffic against a timeline model
    do_reset();
    m_data = 32'h0; m_shadow = 32'h0; m_ctrl = 6'h20; t = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk_in);
      off  = t % SD;
      slot = (t / SD) % 4;
      show = m_ctrl[5] && (off >= BC);
      e_sel  = show ? (4'b0001 << slot) : 4'h0;
      e_seg0 = show ? enc_tab[m_shadow[4*slot +: 4]] : 8'hFF;
      e_seg1 = show ? enc_tab[m_shadow[16 + 4*slot +: 4]] : 8'hFF;
      e_sel2 = m_ctrl[4] & m_ctrl[5];
      e_seg2 = e_sel2 ? enc_tab[m_ctrl[3:0]] : 8'hFF;
      case (addr)
        2'd0:    e_rd = m_data;
        2'd1:    e_rd = {26'h0, m_ctrl};
        2'd2:    e_rd = {29'h0, !show, (m_ctrl[5] ? 2'(slot) : 2'd0)};
        default: e_rd = 32'h0;
      endcase
      chk("rnd_sel", {23'h0, sel2, sel1, sel0}, {23'h0, e_sel2, e_sel, e_sel});
      chk("rnd_seg", {8'h0, seg2, seg1, seg0}, {8'h0, e_seg2, e_seg1, e_seg0});
      chk("rnd_rdata", rdata, e_rd);

      we      = ($urandom_range(0, 15) < 3);
      addr    = 2'($urandom_range(0, 3));
      byte_en = 4'($urandom);
      wdata   = $urandom;
      if (addr == 2'd1) wdata[5] = ($urandom_range(0, 7) != 0);

      en_old = m_ctrl[5];
      d_old  = m_data;
      if (we && addr == 2'd0) begin
        for (int i = 0; i < 4; i++)
          if (byte_en[i]) m_data[8*i +: 8] = wdata[8*i +: 8];
      end else if (we && addr == 2'd1 && byte_en[0]) begin
        m_ctrl = wdata[5:0];
      end
      if (en_old && m_ctrl[5]) begin
        if (t % FRAME == 0) m_shadow = d_old;
        t++;
      end else begin
        t = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
